sync_event_arbiter: RTL
=======================

Name: sync_event_arbiter

Overview:
- Collects asynchronous event lines (interrupt/debug/wake strobes from other clock domains) and brings each through a multi-stage synchronizer chain.
- Converts each synchronized rising edge into a sticky pending bit.
- Round-robin arbitrates pending events onto a single ready/valid output stream carrying the source index.
- Sits between the off-domain event sources and the core's event/interrupt controller. It replaces ad-hoc per-line synchronizers with one shared, sequenced consumer port.

Parameters:
- N_SRC, 4: number of asynchronous event inputs, 2..32.
- SYNC_DEPTH, 3: flops per synchronizer chain, ≥2.
- IDX_W, clog2(N_SRC): derived; width of the source index.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset. Asserting it clears all state immediately. Deassertion is assumed synchronous to clock externally.
- io_evt  input  N_SRC  asynchronous event lines; an event is a 0→1 transition held ≥2 clock periods.
- io_enable  input  N_SRC  per-source enable, synchronous to clock.
- io_out_ready  input  1  consumer accepts the current event.
- io_out_valid  output  1  an event is presented.
- io_out_idx  output  IDX_W  source index of the presented event.
- io_pending  output  N_SRC  current pending vector, for status.
- io_drop_count  output  8  saturating count of events lost to an already-pending source.

Behaviour:
- Reset values (async, on reset_n low):
  - Synchronizer flops, edge-history flops, pending, io_out_valid, io_out_idx and io_drop_count = 0.
  - RR pointer = 0.
- Synchronizer: per source, a SYNC_DEPTH-flop shift chain s[0..D-1]. s[0] samples io_evt[i]. No logic between stages.
- Edge detect:
  - last[i] registers s[D-1].
  - rise[i] = s[D-1] & ~last[i], combinational.
- Pending update (per i, each edge):
  - pending_next = io_enable[i] & ((pending[i] & ~clr[i]) | rise[i]).
  - clr[i] = this cycle's load selects source i.
  - rise wins over clr in the same cycle: the new event stays pending.
  - Disabling a source clears its pending bit and suppresses new rises. The event already in the output register is unaffected.
- Drop:
  - If rise[i] & pending[i] & ~clr[i] & io_enable[i], increment io_drop_count by 1.
  - Saturate at 255.
  - Multiple simultaneous drops in one cycle add their popcount, still saturating.
- Output register: load = ~io_out_valid | io_out_ready.
  - On load with any eligible (pending & io_enable) bit:
    - Select the first eligible index searching upward from ptr with wrap N_SRC-1→0.
    - io_out_valid=1, io_out_idx=selected, clr that bit, ptr = (selected+1) mod N_SRC.
  - On load with nothing eligible: io_out_valid=0; ptr unchanged.
  - While io_out_valid & ~io_out_ready: io_out_idx is held stable and no pending bit is cleared.
- Latency: io_evt rising before clock edge E1 gives s[D-1]=1 after edge E_D and pending=1 after E_(D+1). With an idle output, io_out_valid=1 after E_(D+2) (D=3: 5 edges).
- Throughput: one event per cycle with io_out_ready held high. Back-to-back grants rotate fairly; no source is granted twice while another eligible source waits.
- Level held high: one event only. A new event requires the line to return low for ≥1 synchronized sample.
- Reset mid-operation: all state clears at once. Events in flight in the chains are lost; this is accepted.

Test Plan:
- Single event: raise io_evt[2], all enabled, ready=1 → io_out_valid=1, io_out_idx=2 exactly 5 edges later for one cycle; io_pending returns to 0.
- Simultaneous events: raise io_evt[3:0]=4'b1111 together, ready=1 → idx sequence 0,1,2,3 on consecutive cycles; ptr ends at 0.
- Fairness/backpressure:
  - ptr=2, pending=4'b1011, ready=0 for 4 cycles → valid held with idx=3 stable, pending stays 4'b0011.
  - Then ready=1 → idx sequence 3,0,1.
- Drop: pulse io_evt[1] twice (low gap 3 cycles) while ready=0 and source 1 already pending → io_drop_count=1, only one idx=1 delivered. Repeat 300 times → count saturates at 255.
- Enable gating: io_enable[0]=0, pulse io_evt[0] → no valid, drop_count unchanged. Set io_enable[0]=0 while pending[0]=1 → pending[0] clears next edge.
- Async reset: assert reset_n=0 mid-burst while valid=1 → valid, pending and count read 0 before the next clock edge; after release, the first new event is granted from idx 0 priority.

Source files
------------

// File: rtl/sync_event_arbiter.sv
// Event arbiter: per-line synchronizer chains feed rising-edge detectors that set sticky
// pending bits, which are served round-robin onto one ready/valid index stream.
module sync_event_arbiter #(
  parameter  int N_SRC      = 4,
  parameter  int SYNC_DEPTH = 3,
  localparam int IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] io_evt,
  input  logic [N_SRC-1:0] io_enable,
  input  logic             io_out_ready,
  output logic             io_out_valid,
  output logic [IDX_W-1:0] io_out_idx,
  output logic [N_SRC-1:0] io_pending,
  output logic [7:0]       io_drop_count
);

  localparam logic [IDX_W:0] SRC_CNT = (IDX_W+1)'(N_SRC);

  logic [N_SRC-1:0] sync_r [SYNC_DEPTH];
  logic [N_SRC-1:0] last_r;
  logic [N_SRC-1:0] pending_r;
  logic             valid_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] ptr_r;
  logic [7:0]       drop_cnt_r;

  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] eligible_s;
  logic [N_SRC-1:0] clr_s;
  logic [N_SRC-1:0] drop_s;
  logic [N_SRC-1:0] pending_next_s;
  logic [IDX_W-1:0] sel_s;
  logic [IDX_W-1:0] ptr_next_s;
  logic             found_s;
  logic             load_s;
  logic             grant_s;
  logic [8:0]       drop_sum_s;
  logic [7:0]       drop_cnt_next_s;

  // Modular add on the source index space, wrapping N_SRC-1 -> 0.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W:0]   off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + off;
    return (sum >= SRC_CNT) ? IDX_W'(sum - SRC_CNT) : IDX_W'(sum);
  endfunction

  // Number of set bits in a source vector.
  function automatic logic [8:0] popcount(input logic [N_SRC-1:0] vec);
    logic [8:0] cnt;
    cnt = 9'd0;
    for (int i = 0; i < N_SRC; i++) begin
      cnt = cnt + {8'd0, vec[i]};
    end
    return cnt;
  endfunction

  // Synchronizer chains and the edge-history stage behind them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_DEPTH; k++) begin
        sync_r[k] <= {N_SRC{1'b0}};
      end
      last_r <= {N_SRC{1'b0}};
    end else begin
      sync_r[0] <= io_evt;
      for (int k = 1; k < SYNC_DEPTH; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
      last_r <= sync_r[SYNC_DEPTH-1];
    end
  end

  assign rise_s     = sync_r[SYNC_DEPTH-1] & ~last_r;
  assign eligible_s = pending_r & io_enable;

  // Round-robin pick: scan downward so the lowest offset from ptr wins.
  always_comb begin
    sel_s   = ptr_r;
    found_s = |eligible_s;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      sel_s = eligible_s[wrap_add(ptr_r, (IDX_W+1)'(k))] ? wrap_add(ptr_r, (IDX_W+1)'(k)) : sel_s;
    end
    ptr_next_s = wrap_add(sel_s, (IDX_W+1)'(1));
  end

  // Pending and drop bookkeeping; a same-cycle rise outlives the grant clear.
  always_comb begin
    load_s          = ~valid_r | io_out_ready;
    grant_s         = load_s & found_s;
    clr_s           = grant_s ? ({{(N_SRC-1){1'b0}}, 1'b1} << sel_s) : {N_SRC{1'b0}};
    pending_next_s  = io_enable & ((pending_r & ~clr_s) | rise_s);
    drop_s          = rise_s & pending_r & ~clr_s & io_enable;
    drop_sum_s      = {1'b0, drop_cnt_r} + popcount(drop_s);
    drop_cnt_next_s = (drop_sum_s > 9'd255) ? 8'd255 : drop_sum_s[7:0];
  end

  // Pending vector and saturating drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_r  <= {N_SRC{1'b0}};
      drop_cnt_r <= 8'd0;
    end else begin
      pending_r  <= pending_next_s;
      drop_cnt_r <= drop_cnt_next_s;
    end
  end

  // Output register and rotation pointer; both hold while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      ptr_r   <= {IDX_W{1'b0}};
    end else if (load_s) begin
      valid_r <= found_s;
      if (found_s) begin
        idx_r <= sel_s;
        ptr_r <= ptr_next_s;
      end
    end
  end

  assign io_out_valid  = valid_r;
  assign io_out_idx    = idx_r;
  assign io_pending    = pending_r;
  assign io_drop_count = drop_cnt_r;

endmodule
